sd_fifo_arbiter: RTL and testbench

//  Shares the sdc_controller byte-FIFO port (rd_en/rd_dat, wr_en/wr_dat) between two requesters:

---
 rtl/sd_fifo_arbiter_if.sv | 43 ++++
 rtl/sd_fifo_arbiter.sv | 146 ++++++++++++++
 tb/tb_sd_fifo_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_fifo_arbiter_if.sv
// ============================================================================
// Module   : sd_fifo_arbiter_if
// Purpose  : Requester and sdc_controller FIFO signals shared by sd_fifo_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface sd_fifo_arbiter_if;
  logic       req0, req1;
  logic       dir0, dir1;
  logic       gnt0, gnt1;
  logic       rd_en0, rd_en1;
  logic [7:0] rd_dat0, rd_dat1;
  logic       wr_en0, wr_en1;
  logic [7:0] wr_dat0, wr_dat1;
  logic       done0, done1;
  logic       sd_rd_en;
  logic [7:0] sd_rd_dat;
  logic       sd_wr_en;
  logic [7:0] sd_wr_dat;
  logic       busy;
  logic       owner;
  logic       timeout_err;

  // Arbiter side
  modport slave (
    input  req0, req1, dir0, dir1, rd_en0, rd_en1, wr_en0, wr_en1,
           wr_dat0, wr_dat1, sd_rd_dat,
    output gnt0, gnt1, rd_dat0, rd_dat1, done0, done1, sd_rd_en,
           sd_wr_en, sd_wr_dat, busy, owner, timeout_err
  );

  // Requesters plus sdc_controller side
  modport master (
    output req0, req1, dir0, dir1, rd_en0, rd_en1, wr_en0, wr_en1,
           wr_dat0, wr_dat1, sd_rd_dat,
    input  gnt0, gnt1, rd_dat0, rd_dat1, done0, done1, sd_rd_en,
           sd_wr_en, sd_wr_dat, busy, owner, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/sd_fifo_arbiter.sv
// ============================================================================
// Module   : sd_fifo_arbiter
// Purpose  : Block-granular round-robin share of the sdc_controller byte FIFOs
//            between two requesters. Optional macro SDARB_TIMEOUT_EN adds an
//            idle watchdog that revokes a stalled grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sd_fifo_arbiter #(
  parameter int BLOCK_BYTES    = 512,
  parameter int CNT_W          = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  sd_fifo_arbiter_if.slave   bus
);

  localparam logic [1:0] c_S_IDLE    = 2'd0;
  localparam logic [1:0] c_S_XFER    = 2'd1;
  localparam logic [1:0] c_S_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic             r_gnt;
  logic             r_owner;
  logic             r_dir;
  logic             r_ptr;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  logic w_winner;
  logic w_own_rd;
  logic w_own_wr;
  logic w_count;
  logic w_last;
  logic w_tout;

  // Pointer only matters on a tie; a lone requester always wins.
  assign w_winner = (bus.req0 & bus.req1) ? r_ptr : bus.req1;
  assign w_own_rd = r_owner ? bus.rd_en1 : bus.rd_en0;
  assign w_own_wr = r_owner ? bus.wr_en1 : bus.wr_en0;
  assign w_count  = r_gnt & (r_dir ? w_own_wr : w_own_rd);
  assign w_last   = w_count & (r_cnt == c_CNT_LAST);

`ifdef SDARB_TIMEOUT_EN
  localparam int c_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);

  logic [c_IDLE_W-1:0] r_idle;
  logic                r_tout_err;

  assign w_tout = r_gnt & ~w_count & (r_idle == c_IDLE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle     <= '0;
      r_tout_err <= 1'b0;
    end else begin
      if (!r_gnt || w_count) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + c_IDLE_ONE;
      end
      if (w_tout) begin
        r_tout_err <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = r_tout_err;
`else
  assign w_tout          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
      r_gnt   <= 1'b0;
      r_owner <= 1'b0;
      r_dir   <= 1'b0;
      r_ptr   <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          r_done <= 1'b0;
          if (bus.req0 | bus.req1) begin
            r_owner <= w_winner;
            r_dir   <= w_winner ? bus.dir1 : bus.dir0;
            r_ptr   <= ~w_winner;
            r_gnt   <= 1'b1;
            r_cnt   <= '0;
            r_state <= c_S_XFER;
          end
        end
        c_S_XFER: begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_gnt   <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_S_RELEASE;
          end else if (w_tout) begin
            r_gnt   <= 1'b0;
            r_cnt   <= '0;
            r_state <= c_S_RELEASE;
          end else if (w_count) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_S_RELEASE: begin
          r_done  <= 1'b0;
          r_state <= c_S_IDLE;
        end
        default: begin
          r_gnt   <= 1'b0;
          r_done  <= 1'b0;
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  // Zero-latency datapath so the FIFO handshake timing is unchanged.
  assign bus.gnt0      = r_gnt & ~r_owner;
  assign bus.gnt1      = r_gnt &  r_owner;
  assign bus.done0     = r_done & ~r_owner;
  assign bus.done1     = r_done &  r_owner;
  assign bus.sd_rd_en  = r_gnt & ~r_dir & w_own_rd;
  assign bus.sd_wr_en  = r_gnt &  r_dir & w_own_wr;
  assign bus.sd_wr_dat = r_owner ? bus.wr_dat1 : bus.wr_dat0;
  assign bus.rd_dat0   = r_owner ? 8'h00 : bus.sd_rd_dat;
  assign bus.rd_dat1   = r_owner ? bus.sd_rd_dat : 8'h00;
  assign bus.busy      = (r_state != c_S_IDLE);
  assign bus.owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_sd_fifo_arbiter.sv
// ============================================================================
// Module   : tb_sd_fifo_arbiter
// Purpose  : Directed self-checking bench for sd_fifo_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sd_fifo_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  sd_fifo_arbiter_if bus ();

  sd_fifo_arbiter #(
    .BLOCK_BYTES    (512),
    .CNT_W          (10),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gnt_of(input bit p);
    return p ? bus.gnt1 : bus.gnt0;
  endfunction

  function automatic logic done_of(input bit p);
    return p ? bus.done1 : bus.done0;
  endfunction

  function automatic logic [7:0] rd_dat_of(input bit p);
    return p ? bus.rd_dat1 : bus.rd_dat0;
  endfunction

  task automatic clear_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.dir0 = 0; bus.dir1 = 0;
    bus.rd_en0 = 0; bus.rd_en1 = 0; bus.wr_en0 = 0; bus.wr_en1 = 0;
    bus.wr_dat0 = 8'h00; bus.wr_dat1 = 8'h00; bus.sd_rd_dat = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_strobe(input bit p, input bit dir, input bit en, input logic [7:0] dat);
    if (p) begin
      bus.rd_en1 = en & ~dir; bus.wr_en1 = en & dir; bus.wr_dat1 = dat;
    end else begin
      bus.rd_en0 = en & ~dir; bus.wr_en0 = en & dir; bus.wr_dat0 = dat;
    end
    bus.sd_rd_dat = dat;
  endtask

  // Streams n bytes on port p; when fin is set the block must end exactly here.
  task automatic stream(input bit p, input bit dir, input int n, input bit fin, input string tag);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = 8'(i * 7 + 3);
      set_strobe(p, dir, 1'b1, d);
      #1;
      if (dir) begin
        chk({tag, "_sd_wr_en"}, bus.sd_wr_en, 1);
        chk({tag, "_sd_wr_dat"}, bus.sd_wr_dat, d);
      end else begin
        chk({tag, "_sd_rd_en"}, bus.sd_rd_en, 1);
        chk({tag, "_rd_dat_own"}, rd_dat_of(p), d);
        chk({tag, "_rd_dat_other"}, rd_dat_of(~p), 8'h00);
      end
      chk({tag, "_done_early"}, done_of(p), 0);
      @(posedge clk);
      #1;
    end
    set_strobe(p, dir, 1'b0, 8'h00);
    if (fin) begin
      chk({tag, "_done_pulse"}, done_of(p), 1);
      chk({tag, "_gnt_drop"}, gnt_of(p), 0);
    end
  endtask

  initial begin
    int sent;
    int c;
    logic e_en;
    logic [7:0] e_dat;
    n_cmp  = 0;
    n_fail = 0;

    // Reset held with a pending request and read strobe
    clear_inputs();
    rst_n = 1'b0;
    bus.req0 = 1'b1;
    bus.rd_en0 = 1'b1;
    repeat (4) begin
      tick();
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_owner", bus.owner, 0);
      chk("rst_sd_rd_en", bus.sd_rd_en, 0);
      chk("rst_done0", bus.done0, 0);
      chk("rst_tout", bus.timeout_err, 0);
    end

    // Single read block on port 0
    clear_inputs();
    rst_n = 1'b1;
    tick();
    chk("rd_idle_busy", bus.busy, 0);
    bus.req0 = 1'b1;
    bus.dir0 = 1'b0;
    tick();
    chk("rd_gnt0", bus.gnt0, 1);
    chk("rd_busy", bus.busy, 1);
    chk("rd_owner", bus.owner, 0);
    stream(1'b0, 1'b0, 512, 1'b1, "rd");
    bus.req0 = 1'b0;
    chk("rd_release_busy", bus.busy, 1);
    tick();
    chk("rd_done_once", bus.done0, 0);
    chk("rd_busy_low1", bus.busy, 0);
    tick();
    chk("rd_busy_low2", bus.busy, 0);
    chk("rd_no_regrant", bus.gnt0, 0);

    // Contention: strict alternation 0,1,0
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick();
    chk("ct_b1_gnt0", bus.gnt0, 1);
    chk("ct_b1_gnt1", bus.gnt1, 0);
    stream(1'b0, 1'b0, 512, 1'b1, "ct_b1");
    tick();
    chk("ct_gap_gnt1", bus.gnt1, 0);
    chk("ct_gap_busy", bus.busy, 0);
    tick();
    chk("ct_b2_gnt1", bus.gnt1, 1);
    chk("ct_b2_gnt0", bus.gnt0, 0);
    chk("ct_b2_owner", bus.owner, 1);
    stream(1'b1, 1'b0, 512, 1'b1, "ct_b2");
    tick();
    tick();
    chk("ct_b3_gnt0", bus.gnt0, 1);
    chk("ct_b3_gnt1", bus.gnt1, 0);
    chk("ct_b3_owner", bus.owner, 0);
    stream(1'b0, 1'b0, 512, 1'b1, "ct_b3");
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    tick();

    // Isolation during a port-0 write grant
    do_reset();
    bus.req0 = 1'b1; bus.dir0 = 1'b1;
    tick();
    chk("iso_gnt0", bus.gnt0, 1);
    sent = 0;
    c = 0;
    while (sent < 512 && c < 1000) begin
      e_en  = (c % 3 != 2);
      e_dat = 8'(c * 5 + 1);
      bus.wr_en0 = e_en; bus.wr_dat0 = e_dat;
      bus.wr_en1 = 1'b1; bus.wr_dat1 = 8'hA5;
      bus.rd_en0 = 1'b1;
      #1;
      chk("iso_sd_wr_en", bus.sd_wr_en, e_en);
      chk("iso_sd_rd_en", bus.sd_rd_en, 0);
      if (e_en) chk("iso_sd_wr_dat", bus.sd_wr_dat, e_dat);
      chk("iso_done_early", bus.done0, 0);
      if (e_en) sent++;
      c++;
      @(posedge clk);
      #1;
    end
    bus.req0 = 1'b0;
    bus.wr_en0 = 1'b1;
    #1;
    chk("iso_done_pulse", bus.done0, 1);
    chk("iso_gnt_drop", bus.gnt0, 0);
    chk("iso_release_no_fwd", bus.sd_wr_en, 0);
    clear_inputs();
    tick();
    tick();

    // Request dropped mid-block: block still completes
    do_reset();
    bus.req0 = 1'b1; bus.dir0 = 1'b0;
    tick();
    chk("drop_gnt0", bus.gnt0, 1);
    stream(1'b0, 1'b0, 100, 1'b0, "drop_a");
    bus.req0 = 1'b0;
    chk("drop_gnt_held", bus.gnt0, 1);
    stream(1'b0, 1'b0, 412, 1'b1, "drop_b");
    tick();
    tick();

    // Reset at byte 300 aborts; next block counts from zero
    bus.req0 = 1'b1;
    tick();
    chk("mrst_gnt0", bus.gnt0, 1);
    stream(1'b0, 1'b0, 300, 1'b0, "mrst_a");
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    tick();
    chk("mrst_gnt_low", bus.gnt0, 0);
    chk("mrst_busy_low", bus.busy, 0);
    chk("mrst_no_done", bus.done0, 0);
    rst_n = 1'b1;
    bus.req0 = 1'b1;
    tick();
    chk("mrst_regrant", bus.gnt0, 1);
    stream(1'b0, 1'b0, 512, 1'b1, "mrst_b");
    bus.req0 = 1'b0;
    tick();
    tick();

`ifdef SDARB_TIMEOUT_EN
    // Stalled port-1 write grant is revoked after 16 idle cycles
    do_reset();
    bus.req1 = 1'b1; bus.dir1 = 1'b1;
    tick();
    chk("to_gnt1", bus.gnt1, 1);
    stream(1'b1, 1'b1, 5, 1'b0, "to");
    bus.req1 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("to_gnt_held", bus.gnt1, 1);
      chk("to_err_low", bus.timeout_err, 0);
    end
    tick();
    chk("to_gnt_drop", bus.gnt1, 0);
    chk("to_err_set", bus.timeout_err, 1);
    chk("to_no_done", bus.done1, 0);
    repeat (3) begin
      tick();
      chk("to_no_done_later", bus.done1, 0);
      chk("to_err_sticky", bus.timeout_err, 1);
    end
`else
    chk("no_tout_err", bus.timeout_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
